// File: rtl/sub32_serial.sv
// Digit-serial subtractor: a - b - b_in, one DIGIT-wide slice per clock, LSB first.
// Optional signed-overflow output ovf_o is built only when SUB_OVF_EN is defined.
module sub32_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff_o,
    output logic             bo_o
`ifdef SUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIGIT:0]   slice;

    // One digit slice; the extra MSB is the borrow out of the slice.
    function automatic logic [DIGIT:0] sub_digit(input logic [DIGIT-1:0] x,
                                                 input logic [DIGIT-1:0] y,
                                                 input logic             bin);
        return {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
    endfunction

    assign slice = sub_digit(a_q[DIGIT-1:0], b_q[DIGIT-1:0], brw_q);

`ifdef SUB_OVF_EN
    logic sa_q, sa_d, sb_q, sb_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
`ifdef SUB_OVF_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = b_in;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SUB_OVF_EN
                    sa_d    = a[WIDTH-1];
                    sb_d    = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                // Result fills from the MSB end so after N steps digit 0 sits at the LSB.
                res_d = {slice[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                brw_d = slice[DIGIT];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef SUB_OVF_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
`ifdef SUB_OVF_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff_o    = res_q;
    assign bo_o      = brw_q;
`ifdef SUB_OVF_EN
    assign ovf_o     = (sa_q != sb_q) && (res_q[WIDTH-1] != sa_q);
`endif

endmodule

// File: tb/tb_sub32_serial.sv
// Self-checking bench for sub32_serial against an arithmetic reference model.
module tb_sub32_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        b_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff_o;
    logic        bo_o;
    logic        ovf_w;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    sub32_serial #(.WIDTH(32), .DIGIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff_o    (diff_o),
        .bo_o      (bo_o)
`ifdef SUB_OVF_EN
        ,
        .ovf_o     (ovf_w)
`endif
    );

`ifndef SUB_OVF_EN
    assign ovf_w = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_diff(input logic [31:0] x, input logic [31:0] y, input logic bi);
        longint unsigned m;
        m = (longint'(x) - longint'(y) - longint'(bi)) & 64'hFFFF_FFFF;
        return m[31:0];
    endfunction

    function automatic logic ref_bo(input logic [31:0] x, input logic [31:0] y, input logic bi);
        return (longint'(y) + longint'(bi)) > longint'(x);
    endfunction

    function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y, input logic bi);
        longint s;
        s = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Accepts one operand set and waits for out_valid; leaves the DUT in DONE.
    task automatic start_and_wait(input logic [31:0] x, input logic [31:0] y, input logic bi,
                                  output int lat);
        a = x; b = y; b_in = bi; in_valid = 1'b1;
        lat = 0;
        while (!in_ready && lat < 50) begin tick(); lat++; end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        if (!out_valid) lat = -1;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; b_in = 1'b0;
        tick(); tick();
        rst = 1'b0;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total++; if (diff_o !== 32'h0) $display("FAIL reset_diff got=%h exp=0", diff_o); else pass_cnt++;
        total++; if (bo_o !== 1'b0) $display("FAIL reset_bo got=%b exp=0", bo_o); else pass_cnt++;
        total++; if (ovf_w !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf_w); else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [31:0] va [5] = '{32'h0000_0010, 32'h0000_0000, 32'h1234_5678, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] vb [5] = '{32'h0000_0001, 32'h0000_0001, 32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFF};
        logic        vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            start_and_wait(va[i], vb[i], vc[i], lat);
            total++; if (lat !== 8) $display("FAIL dir%0d_latency got=%0d exp=8", i, lat); else pass_cnt++;
            total++;
            if (diff_o !== ref_diff(va[i], vb[i], vc[i]))
                $display("FAIL dir%0d_diff got=%h exp=%h", i, diff_o, ref_diff(va[i], vb[i], vc[i]));
            else pass_cnt++;
            total++;
            if (bo_o !== ref_bo(va[i], vb[i], vc[i]))
                $display("FAIL dir%0d_bo got=%b exp=%b", i, bo_o, ref_bo(va[i], vb[i], vc[i]));
            else pass_cnt++;
`ifdef SUB_OVF_EN
            total++;
            if (ovf_w !== ref_ovf(va[i], vb[i], vc[i]))
                $display("FAIL dir%0d_ovf got=%b exp=%b", i, ovf_w, ref_ovf(va[i], vb[i], vc[i]));
            else pass_cnt++;
`endif
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] x, y;
        logic        bi;
        int lat;
        x = $urandom; y = $urandom; bi = 1'($urandom);
        start_and_wait(x, y, bi, lat);
        for (int c = 0; c < 5; c++) begin
            in_valid = ~in_valid; a = $urandom; b = $urandom; b_in = 1'($urandom);
            tick();
            total++; if (diff_o !== ref_diff(x, y, bi)) $display("FAIL bp_diff c%0d got=%h exp=%h", c, diff_o, ref_diff(x, y, bi)); else pass_cnt++;
            total++; if (bo_o !== ref_bo(x, y, bi)) $display("FAIL bp_bo c%0d got=%b exp=%b", c, bo_o, ref_bo(x, y, bi)); else pass_cnt++;
            total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid c%0d got=%b exp=1", c, out_valid); else pass_cnt++;
            total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready c%0d got=%b exp=0", c, in_ready); else pass_cnt++;
        end
        in_valid = 1'b0;
        release_result();
        total++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        int lat;
        a = 32'hDEAD_BEEF; b = 32'h1357_9BDF; b_in = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total++; if (diff_o !== 32'h0) $display("FAIL mid_rst_diff got=%h exp=0", diff_o); else pass_cnt++;
        total++; if (bo_o !== 1'b0) $display("FAIL mid_rst_bo got=%b exp=0", bo_o); else pass_cnt++;
        start_and_wait(32'd5, 32'd3, 1'b0, lat);
        total++; if (lat !== 8) $display("FAIL mid_rst_latency got=%0d exp=8", lat); else pass_cnt++;
        total++; if (diff_o !== 32'h2) $display("FAIL mid_rst_diff5m3 got=%h exp=2", diff_o); else pass_cnt++;
        total++; if (bo_o !== 1'b0) $display("FAIL mid_rst_bo5m3 got=%b exp=0", bo_o); else pass_cnt++;
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [31:0] qa [$];
        logic [31:0] qb [$];
        logic        qc [$];
        logic [31:0] ea, eb;
        logic        ec;
        int results = 0;
        int cyc = 0;
        int last = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (results < 1000 && cyc < 15000) begin
            if (in_ready) begin
                a = $urandom; b = $urandom; b_in = 1'($urandom);
                if ($urandom_range(0, 7) == 0) b = a;
                qa.push_back(a); qb.push_back(b); qc.push_back(b_in);
            end
            if (out_valid) begin
                if (qa.size() == 0) begin
                    total++; $display("FAIL b2b_unexpected_result cyc=%0d got=%h exp=none", cyc, diff_o);
                end else begin
                    ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
                    total++; if (diff_o !== ref_diff(ea, eb, ec)) $display("FAIL b2b_diff r%0d got=%h exp=%h", results, diff_o, ref_diff(ea, eb, ec)); else pass_cnt++;
                    total++; if (bo_o !== ref_bo(ea, eb, ec)) $display("FAIL b2b_bo r%0d got=%b exp=%b", results, bo_o, ref_bo(ea, eb, ec)); else pass_cnt++;
`ifdef SUB_OVF_EN
                    total++; if (ovf_w !== ref_ovf(ea, eb, ec)) $display("FAIL b2b_ovf r%0d got=%b exp=%b", results, ovf_w, ref_ovf(ea, eb, ec)); else pass_cnt++;
`endif
                end
                if (last >= 0) begin
                    total++; if (cyc - last !== 10) $display("FAIL b2b_interval r%0d got=%0d exp=10", results, cyc - last); else pass_cnt++;
                end
                last = cyc;
                results++;
            end
            tick();
            cyc++;
        end
        total++; if (results !== 1000) $display("FAIL b2b_result_count got=%0d exp=1000", results); else pass_cnt++;
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
